// File: rtl/wb_pkg.sv
// Shared definitions for the write-back select stage.
//   Source lane indices, load-extension type codes and the default link offset.
package wb_pkg;

  localparam int unsigned WB_SRC_ALU  = 0;
  localparam int unsigned WB_SRC_MEM  = 1;
  localparam int unsigned WB_SRC_LINK = 2;
  localparam int unsigned WB_SRC_HILO = 3;

  localparam int unsigned LD_TYPE_W = 3;
  localparam int unsigned LD_OFS_W  = 2;

  localparam logic [LD_TYPE_W-1:0] LD_W  = 3'd0;
  localparam logic [LD_TYPE_W-1:0] LD_B  = 3'd1;
  localparam logic [LD_TYPE_W-1:0] LD_BU = 3'd2;
  localparam logic [LD_TYPE_W-1:0] LD_H  = 3'd3;
  localparam logic [LD_TYPE_W-1:0] LD_HU = 3'd4;

  localparam int unsigned DEFAULT_LINK_OFS = 4;

endpackage

// File: rtl/wb_select_stage_load_ext.sv
// Combinational load-data alignment and extension (module wb_load_ext).
//   data     : raw memory-data lane
//   ld_type  : LD_W / LD_B / LD_BU / LD_H / LD_HU (other codes behave as word)
//   ld_ofs   : byte offset of the access, shifts the lane right by 8*ld_ofs
//   data_ext : aligned and extended result
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]    data,
  input  logic [LD_TYPE_W-1:0] ld_type,
  input  logic [LD_OFS_W-1:0]  ld_ofs,
  output logic [DATA_W-1:0]    data_ext
);

  logic [DATA_W-1:0] shifted;

  // Bring the addressed byte/halfword down to bit 0.
  assign shifted = data >> {ld_ofs, 3'b000};

  always_comb begin
    data_ext = shifted;
    case (ld_type)
      LD_B:    data_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      LD_BU:   data_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      LD_H:    data_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      LD_HU:   data_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: data_ext = shifted;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB pipeline register with N-way write-back source select, feeding
// register-file write port 3 in decode.
//   clk, reset          : clock and synchronous active-high reset
//   stall_W, flush_W    : hold / bubble control for the W register
//   valid_M, regwrite_M, wa_M, sel_M, src_M : instruction leaving M
//   ld_type_M, ld_ofs_M : load extension controls (WB_LOAD_EXT_EN only)
//   WD3_D, A3_D, WE3_D  : register-file write data / address / enable
//   valid_W             : W holds a valid instruction
//   retired_cnt         : retired-instruction counter (wraps)
// Optional: define WB_LOAD_EXT_EN to align/extend the memory lane (source 1).
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NSRC     = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned LINK_IDX = WB_SRC_LINK,
  parameter int unsigned LINK_OFS = DEFAULT_LINK_OFS,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_W,
  input  logic                   flush_W,
  input  logic                   valid_M,
  input  logic                   regwrite_M,
  input  logic [REG_AW-1:0]      wa_M,
  input  logic [SEL_W-1:0]       sel_M,
  input  logic [NSRC*DATA_W-1:0] src_M,
  input  logic [LD_TYPE_W-1:0]   ld_type_M,
  input  logic [LD_OFS_W-1:0]    ld_ofs_M,
  output logic [DATA_W-1:0]      WD3_D,
  output logic [REG_AW-1:0]      A3_D,
  output logic                   WE3_D,
  output logic                   valid_W,
  output logic [CNT_W-1:0]       retired_cnt
);

  localparam int unsigned SRC_W = NSRC * DATA_W;

  logic             regwrite_w;
  logic [SEL_W-1:0] sel_w;
  logic [SRC_W-1:0] src_w;

  // W register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_W    <= 1'b0;
      regwrite_w <= 1'b0;
      A3_D       <= '0;
      sel_w      <= '0;
      src_w      <= '0;
    end else if (flush_W) begin
      valid_W    <= 1'b0;
      regwrite_w <= 1'b0;
      A3_D       <= '0;
      sel_w      <= '0;
      src_w      <= '0;
    end else if (!stall_W) begin
      valid_W    <= valid_M;
      regwrite_w <= regwrite_M;
      A3_D       <= wa_M;
      sel_w      <= sel_M;
      src_w      <= src_M;
    end
  end

  // An instruction retires when it leaves W; a flush still lets it leave.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (valid_W && !stall_W) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [LD_TYPE_W-1:0] ld_type_w;
  logic [LD_OFS_W-1:0]  ld_ofs_w;
  logic [DATA_W-1:0]    mem_ext;

  always_ff @(posedge clk) begin
    if (reset || flush_W) begin
      ld_type_w <= '0;
      ld_ofs_w  <= '0;
    end else if (!stall_W) begin
      ld_type_w <= ld_type_M;
      ld_ofs_w  <= ld_ofs_M;
    end
  end

  wb_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .data     (src_w[WB_SRC_MEM*DATA_W +: DATA_W]),
    .ld_type  (ld_type_w),
    .ld_ofs   (ld_ofs_w),
    .data_ext (mem_ext)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{ld_type_M, ld_ofs_M};
`endif

  // Source select; indices at or above NSRC produce zero.
  always_comb begin
    WD3_D = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (sel_w == SEL_W'(k)) begin
        if (k == LINK_IDX) begin
          WD3_D = src_w[k*DATA_W +: DATA_W] + DATA_W'(LINK_OFS);
`ifdef WB_LOAD_EXT_EN
        end else if (k == WB_SRC_MEM) begin
          WD3_D = mem_ext;
`endif
        end else begin
          WD3_D = src_w[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // $0 is hard-wired, so never issue a write to it.
  assign WE3_D = valid_W & regwrite_w & (A3_D != '0);

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 8;

  logic            clk = 1'b0;
  logic            reset, stall_W, flush_W, valid_M, regwrite_M;
  logic [AW-1:0]   wa_M;
  logic [SW-1:0]   sel_M;
  logic [NS*DW-1:0] src_M;
  logic [2:0]      ld_type_M;
  logic [1:0]      ld_ofs_M;
  logic [DW-1:0]   WD3_D;
  logic [AW-1:0]   A3_D;
  logic            WE3_D, valid_W;
  logic [CW-1:0]   retired_cnt;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  wb_select_stage #(
    .DATA_W(DW), .REG_AW(AW), .NSRC(NS), .SEL_W(SW),
    .LINK_IDX(2), .LINK_OFS(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .stall_W(stall_W), .flush_W(flush_W),
    .valid_M(valid_M), .regwrite_M(regwrite_M), .wa_M(wa_M), .sel_M(sel_M),
    .src_M(src_M), .ld_type_M(ld_type_M), .ld_ofs_M(ld_ofs_M),
    .WD3_D(WD3_D), .A3_D(A3_D), .WE3_D(WE3_D), .valid_W(valid_W),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Behavioural model of what W holds.
  bit            m_valid, m_rw;
  logic [AW-1:0] m_wa;
  int            m_sel;
  logic [DW-1:0] m_src [NS];
  int            m_ty, m_ofs;
  logic [CW-1:0] m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_rw = 0; m_wa = '0; m_sel = 0; m_ty = 0; m_ofs = 0; m_cnt = '0;
      for (int i = 0; i < NS; i++) m_src[i] = '0;
    end else begin
      if (m_valid && !stall_W) m_cnt = m_cnt + 8'd1;
      if (flush_W) begin
        m_valid = 0; m_rw = 0; m_wa = '0; m_sel = 0; m_ty = 0; m_ofs = 0;
        for (int i = 0; i < NS; i++) m_src[i] = '0;
      end else if (!stall_W) begin
        m_valid = valid_M; m_rw = regwrite_M; m_wa = wa_M; m_sel = int'(sel_M);
        m_ty = int'(ld_type_M); m_ofs = int'(ld_ofs_M);
        for (int i = 0; i < NS; i++) m_src[i] = src_M[i*DW +: DW];
      end
    end
  end

  function automatic logic [DW-1:0] exp_wd();
    logic [DW-1:0] v;
    if (m_sel >= NS) return '0;
    if (m_sel == 2) return m_src[2] + 32'd4;
`ifdef WB_LOAD_EXT_EN
    if (m_sel == 1) begin
      v = m_src[1] >> (8 * m_ofs);
      case (m_ty)
        1: return v[7]  ? ((v & 32'hFF)   | 32'hFFFFFF00) : (v & 32'hFF);
        2: return v & 32'hFF;
        3: return v[15] ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
        4: return v & 32'hFFFF;
        default: return v;
      endcase
    end
`endif
    v = m_src[m_sel];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("model_wd",    WD3_D, exp_wd());
      chk("model_a3",    32'(A3_D), 32'(m_wa));
      chk("model_we",    32'(WE3_D), 32'(m_valid && m_rw && (m_wa != 0)));
      chk("model_valid", 32'(valid_W), 32'(m_valid));
      chk("model_cnt",   32'(retired_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_src(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    src_M = {s2, s1, s0};
  endtask

  logic [31:0] ext_exp [4];
  logic [2:0]  ext_ty  [4];
  logic [1:0]  ext_ofs [4];

  initial begin
    reset = 1; stall_W = 0; flush_W = 0; valid_M = 0; regwrite_M = 0;
    wa_M = '0; sel_M = '0; src_M = '0; ld_type_M = '0; ld_ofs_M = '0;
    step(); step();
    checking = 1'b1;
    chk("reset_wd", WD3_D, 32'h0);
    chk("reset_a3", 32'(A3_D), 32'd0);
    chk("reset_we", 32'(WE3_D), 32'd0);
    chk("reset_valid", 32'(valid_W), 32'd0);
    chk("reset_cnt", 32'(retired_cnt), 32'd0);

    // Basic ALU write-back.
    reset = 0; valid_M = 1; regwrite_M = 1; wa_M = 5'd8; sel_M = 2'd0;
    set_src(32'h12345678, 32'h0, 32'h0);
    step();
    chk("alu_wd", WD3_D, 32'h12345678);
    chk("alu_a3", 32'(A3_D), 32'd8);
    chk("alu_we", 32'(WE3_D), 32'd1);
    chk("alu_cnt0", 32'(retired_cnt), 32'd0);
    valid_M = 0;
    step();
    chk("alu_cnt1", 32'(retired_cnt), 32'd1);

    // Link offset and wrap.
    valid_M = 1; sel_M = 2'd2; set_src(32'h0, 32'h0, 32'h00400010);
    step();
    chk("link_wd", WD3_D, 32'h00400014);
    set_src(32'h0, 32'h0, 32'hFFFFFFFC);
    step();
    chk("link_wrap", WD3_D, 32'h00000000);

    // $0 suppression and out-of-range select.
    sel_M = 2'd0; wa_M = 5'd0; set_src(32'hABCD1234, 32'h0, 32'h0);
    step();
    chk("r0_we", 32'(WE3_D), 32'd0);
    chk("r0_wd", WD3_D, 32'hABCD1234);
    sel_M = 2'd3; wa_M = 5'd9;
    step();
    chk("oor_wd", WD3_D, 32'h0);
    chk("oor_we", 32'(WE3_D), 32'd1);

    // Stall freezes W.
    sel_M = 2'd0; wa_M = 5'd5; set_src(32'h55, 32'h0, 32'h0);
    step();
    stall_W = 1;
    for (int i = 0; i < 3; i++) begin
      set_src($urandom, $urandom, $urandom); wa_M = 5'($urandom);
      step();
      chk("stall_wd", WD3_D, 32'h55);
      chk("stall_a3", 32'(A3_D), 32'd5);
    end
    flush_W = 1;
    step();
    chk("stflush_valid", 32'(valid_W), 32'd0);
    chk("stflush_we", 32'(WE3_D), 32'd0);
    stall_W = 0; flush_W = 0;

    // Reset during a stall.
    valid_M = 1; wa_M = 5'd7; sel_M = 2'd0; set_src(32'h77, 32'h0, 32'h0);
    step();
    chk("pre_rst_valid", 32'(valid_W), 32'd1);
    stall_W = 1; reset = 1;
    step();
    chk("rst_stall_valid", 32'(valid_W), 32'd0);
    chk("rst_stall_wd", WD3_D, 32'h0);
    chk("rst_stall_a3", 32'(A3_D), 32'd0);
    chk("rst_stall_cnt", 32'(retired_cnt), 32'd0);
    stall_W = 0; reset = 0;

    // Counter wrap: continuous retirement after reset.
    valid_M = 1; regwrite_M = 1; wa_M = 5'd1; sel_M = 2'd0;
    step();
    chk("wrap_start", 32'(retired_cnt), 32'd0);
    for (int i = 0; i < 255; i++) step();
    chk("wrap_ff", 32'(retired_cnt), 32'hFF);
    step();
    chk("wrap_zero", 32'(retired_cnt), 32'h00);

`ifdef WB_LOAD_EXT_EN
    ext_ty[0] = 3'd1; ext_ofs[0] = 2'd3; ext_exp[0] = 32'hFFFFFF80;
    ext_ty[1] = 3'd2; ext_ofs[1] = 2'd1; ext_exp[1] = 32'h0000007F;
    ext_ty[2] = 3'd3; ext_ofs[2] = 2'd2; ext_exp[2] = 32'hFFFF80FF;
    ext_ty[3] = 3'd4; ext_ofs[3] = 2'd0; ext_exp[3] = 32'h00007F01;
    sel_M = 2'd1; wa_M = 5'd3; set_src(32'h0, 32'h80FF7F01, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ld_type_M = ext_ty[i]; ld_ofs_M = ext_ofs[i];
      step();
      chk("load_ext", WD3_D, ext_exp[i]);
    end
`else
    ext_exp[0] = 32'h80FF7F01;
    sel_M = 2'd1; wa_M = 5'd3; set_src(32'h0, 32'h80FF7F01, 32'h0);
    ld_type_M = 3'd1; ld_ofs_M = 2'd3;
    step();
    chk("mem_raw", WD3_D, ext_exp[0]);
`endif

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 499) == 0);
      stall_W    = ($urandom_range(0, 3) == 0);
      flush_W    = ($urandom_range(0, 7) == 0);
      valid_M    = ($urandom_range(0, 3) != 0);
      regwrite_M = ($urandom_range(0, 3) != 0);
      wa_M       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      sel_M      = 2'($urandom);
      set_src($urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom);
      ld_type_M  = 3'($urandom);
      ld_ofs_M   = 2'($urandom);
      step();
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
Parametrised MEM/WB pipeline register combined with an N-way write-back source select. It feeds register-file port 3 (WD3_D/A3_D/WE3_D) in the decode stage.
- Generalises the 2:1 Jal write-back select to NSRC sources.
- Adds stall/flush control, $0 write suppression and a link-offset adder.
- Adds a retired-instruction counter.

Parameters:
DATA_W, 32, data/PC width
REG_AW, 5, register-file address width
NSRC, 4, number of write-back sources (min 2)
SEL_W, 2, source-select width, must satisfy 2^SEL_W >= NSRC
LINK_IDX, 2, index of the source treated as link PC
LINK_OFS, 4, constant added to the link source in W
CNT_W, 32, retired-counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-high reset
stall_W  in  1  hold W register contents
flush_W  in  1  insert bubble into W
valid_M  in  1  instruction in M is valid
regwrite_M  in  1  instruction writes the register file
wa_M  in  REG_AW  destination register
sel_M  in  SEL_W  write-back source index
src_M  in  NSRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W]
ld_type_M  in  3  load extension type (used only with LOAD_EXT_EN)
ld_ofs_M  in  2  byte offset of load address (used only with LOAD_EXT_EN)
WD3_D  out  DATA_W  write-back data
A3_D  out  REG_AW  write-back address
WE3_D  out  1  write-back enable
valid_W  out  1  W stage holds a valid instruction
retired_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Interface: one clock, clk. Reset is synchronous, active-high, named reset.
- W-stage register update on the rising edge of clk, priority reset > flush_W > stall_W > load:
  - reset: all W registers are 0, so valid_W=0, WE3_D=0, A3_D=0, WD3_D=0, retired_cnt=0.
  - flush_W: valid and regwrite registers cleared; data, address and select registers cleared to 0. Flush wins over a simultaneous stall.
  - stall_W (without flush): all W registers hold.
  - Otherwise: capture valid_M, regwrite_M, wa_M, sel_M and all src_M lanes.
- Latency: one cycle from M inputs to the W outputs.
- WD3_D is combinational from the W registers:
  - sel_W == LINK_IDX: src[LINK_IDX] + LINK_OFS, modulo 2^DATA_W (wraps, no carry out).
  - sel_W < NSRC, other index: src[sel_W] unmodified.
  - sel_W >= NSRC: 0.
- WE3_D = valid_W & regwrite_W & (A3_D != 0). Writes to $0 are never issued; WD3_D still reflects the selected data.
- A3_D is the registered wa.
- retired_cnt increments by 1 on each edge where valid_W=1, stall_W=0 and reset=0.
  - Wraps to 0 after all-ones.
  - A flush_W in the same cycle still counts the instruction that is leaving W.
- Reset asserted mid-stall clears everything on that edge; stall_W has no effect while reset is high.

Optional Feature:
Macro WB_LOAD_EXT_EN.
- Defined: source 1 is the memory-data lane. ld_type_M and ld_ofs_M are registered with the same reset/flush/stall rules. When sel_W==1, the lane is shifted right by 8*ld_ofs and extended according to ld_type:
  - 0 = word
  - 1 = lb (sign-extend byte)
  - 2 = lbu (zero-extend byte)
  - 3 = lh (sign-extend halfword)
  - 4 = lhu (zero-extend halfword)
  - 5-7 = word
- Undefined: ld_type_M/ld_ofs_M are ignored and not registered; source 1 passes unmodified.

Decomposition:
- Shared package wb_pkg holds:
  - localparams for source indices: WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_LINK=2, WB_SRC_HILO=3.
  - load-type codes LD_W, LD_B, LD_BU, LD_H, LD_HU.
  - DEFAULT_LINK_OFS.
- One natural sub-module, wb_load_ext (combinational shift/extend), instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- Reset, then sel_M=0, src0=0x12345678, wa_M=8, regwrite_M=1, valid_M=1 -> next cycle WD3_D=0x12345678, A3_D=8, WE3_D=1, retired_cnt increments 0->1 on the following edge.
- Link: sel_M=2, src2=0x00400010 -> WD3_D=0x00400014; then src2=0xFFFFFFFC -> WD3_D=0x00000000 (wrap).
- $0 write: wa_M=0, regwrite_M=1 -> WE3_D=0 while WD3_D shows the selected data; out-of-range sel_M with NSRC=3 -> WD3_D=0.
- Stall 3 cycles with changing M inputs -> outputs frozen and retired_cnt frozen; stall_W and flush_W together -> valid_W=0, WE3_D=0 next cycle.
- Reset asserted during a stall with valid_W=1 -> all outputs 0 on that edge; retired_cnt=0.
- With WB_LOAD_EXT_EN: src1=0x80FF7F01.
  - ld_type=1, ofs=3 -> 0xFFFFFF80.
  - ld_type=2, ofs=1 -> 0x0000007F.
  - ld_type=3, ofs=2 -> 0xFFFF80FF.
  - ld_type=4, ofs=0 -> 0x00007F01.
